// File: rtl/tdm_demux_pkg.sv
// Shared constants, state encoding and shadow-select helper for the tdm_demux4 receiver.
package tdm_demux_pkg;

   localparam int NCH      = 4;
   localparam int IDX_W    = 2;
   localparam int ERRCNT_W = 8;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   // One-hot write enable for the shadow slot addressed by idx; the last channel has no slot.
   function automatic logic [NCH-2:0] shadow_sel(input logic [IDX_W-1:0] idx);
      logic [NCH-2:0] sel;
      sel = {(NCH-1){1'b0}};
      if (idx < IDX_W'(NCH-1)) begin
         sel[idx] = 1'b1;
      end else begin
         sel = {(NCH-1){1'b0}};
      end
      return sel;
   endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-beat input and parallel-frame output bundle of tdm_demux4.
// err_cnt is present only when TDM_DEMUX_ERRCNT_EN is defined.
interface tdm_demux4_if #(parameter int DATA_W = 1);
   import tdm_demux_pkg::*;

   logic              in_valid;
   logic              in_sync;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] f0;
   logic [DATA_W-1:0] f1;
   logic [DATA_W-1:0] f2;
   logic [DATA_W-1:0] f3;
   logic              frame_valid;
   logic              locked;
   logic              sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_cnt;
`endif

   modport master (
      output in_valid, in_sync, din,
      input  f0, f1, f2, f3, frame_valid, locked, sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
      , input err_cnt
`endif
   );

   modport slave (
      input  in_valid, in_sync, din,
      output f0, f1, f2, f3, frame_valid, locked, sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
      , output err_cnt
`endif
   );

endinterface

// File: rtl/tdm_demux_ctrl.sv
// Framing FSM and channel index for tdm_demux4; emits shadow write enables,
// the frame-complete strobe and the framing-violation strobe for the current beat.
module tdm_demux_ctrl
   import tdm_demux_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic           in_sync,
   output logic [NCH-2:0] shadow_we,
   output logic           frame_done,
   output logic           sync_err,
   output logic           locked
);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_nxt_s;

   // Decode the current beat against state and index; idle cycles change nothing.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      shadow_we   = {(NCH-1){1'b0}};
      frame_done  = 1'b0;
      sync_err    = 1'b0;
      if (in_valid) begin
         case (state_r)
            HUNT: begin
               if (in_sync) begin
                  shadow_we   = shadow_sel(IDX_W'(0));
                  idx_nxt_s   = IDX_W'(1);
                  state_nxt_s = LOCK;
               end else begin
                  idx_nxt_s   = IDX_W'(0);
               end
            end
            LOCK: begin
               if (in_sync) begin
                  // A sync mid-frame restarts the frame from this beat.
                  shadow_we = shadow_sel(IDX_W'(0));
                  idx_nxt_s = IDX_W'(1);
                  sync_err  = (idx_r != IDX_W'(0));
               end else if (idx_r == IDX_W'(0)) begin
                  sync_err    = 1'b1;
                  state_nxt_s = HUNT;
               end else if (idx_r == IDX_W'(NCH-1)) begin
                  frame_done = 1'b1;
                  idx_nxt_s  = IDX_W'(0);
               end else begin
                  shadow_we = shadow_sel(idx_r);
                  idx_nxt_s = idx_r + IDX_W'(1);
               end
            end
            default: begin
               state_nxt_s = HUNT;
               idx_nxt_s   = IDX_W'(0);
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State, index and registered lock indication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= HUNT;
         idx_r   <= IDX_W'(0);
         locked  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
         locked  <= (state_nxt_s == LOCK);
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 time-division demultiplexer: collects sync-framed serial beats into f0..f3.
// Define TDM_DEMUX_ERRCNT_EN to add a saturating sync-error counter (err_cnt).
module tdm_demux4
   import tdm_demux_pkg::*;
#(
   parameter int DATA_W = 1
)(
   input  logic         clk,
   input  logic         rst,
   tdm_demux4_if.slave  bus
);

   logic [NCH-2:0]    shadow_we_s;
   logic              frame_done_s;
   logic              sync_err_s;
   logic              locked_s;
   logic [DATA_W-1:0] shadow_r [NCH-1];
   logic [DATA_W-1:0] f_r [NCH];
   logic              frame_valid_r;
   logic              sync_err_r;

   tdm_demux_ctrl u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (bus.in_valid),
      .in_sync    (bus.in_sync),
      .shadow_we  (shadow_we_s),
      .frame_done (frame_done_s),
      .sync_err   (sync_err_s),
      .locked     (locked_s)
   );

   // Shadow capture of channels 0..2, frame publish on the last beat, strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH-1; i++) shadow_r[i] <= {DATA_W{1'b0}};
         for (int i = 0; i < NCH; i++)   f_r[i]      <= {DATA_W{1'b0}};
         frame_valid_r <= 1'b0;
         sync_err_r    <= 1'b0;
      end else begin
         for (int i = 0; i < NCH-1; i++) begin
            if (shadow_we_s[i]) shadow_r[i] <= bus.din;
         end
         if (frame_done_s) begin
            for (int i = 0; i < NCH-1; i++) f_r[i] <= shadow_r[i];
            f_r[NCH-1] <= bus.din;
         end
         frame_valid_r <= frame_done_s;
         sync_err_r    <= sync_err_s;
      end
   end

   assign bus.f0          = f_r[0];
   assign bus.f1          = f_r[1];
   assign bus.f2          = f_r[2];
   assign bus.f3          = f_r[3];
   assign bus.frame_valid = frame_valid_r;
   assign bus.sync_err    = sync_err_r;
   assign bus.locked      = locked_s;

`ifdef TDM_DEMUX_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_cnt_r;

   // Saturating count of framing violations since reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_r <= {ERRCNT_W{1'b0}};
      end else if (sync_err_s && (err_cnt_r != {ERRCNT_W{1'b1}})) begin
         err_cnt_r <= err_cnt_r + ERRCNT_W'(1);
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign bus.err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: directed beats push expected frame/error events,
// a negedge monitor pops and compares them whenever frame_valid or sync_err pulses.
module tb_tdm_demux4;

   typedef struct packed {
      logic       is_err;
      logic [3:0] f;
   } ev_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   ev_t  exp_q[$];
   logic [3:0] last_f;

   tdm_demux4_if #(.DATA_W(1)) bus ();

   tdm_demux4 #(.DATA_W(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] fpack();
      return {bus.f0, bus.f1, bus.f2, bus.f3};
   endfunction

   // Monitor: every output pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (!rst && (bus.frame_valid || bus.sync_err)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {30'd0, bus.sync_err, bus.frame_valid}, 32'd0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("event_kind", {30'd0, bus.sync_err, bus.frame_valid}, {30'd0, e.is_err, ~e.is_err});
            chk("event_f", {28'd0, fpack()}, {28'd0, e.f});
         end
      end
   end

   task automatic beat(input logic s, input logic d);
      bus.in_valid = 1'b1;
      bus.in_sync  = s;
      bus.din      = d;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      bus.din      = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_frame(input logic [3:0] f);
      ev_t e;
      e.is_err = 1'b0;
      e.f      = f;
      exp_q.push_back(e);
      last_f = f;
   endtask

   task automatic push_err();
      ev_t e;
      e.is_err = 1'b1;
      e.f      = last_f;
      exp_q.push_back(e);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      last_f = 4'b0000;
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      bus.din      = 1'b0;
      rst = 1'b1;
      #12;
      chk("rst_f", {28'd0, fpack()}, 32'd0);
      chk("rst_locked", {31'd0, bus.locked}, 32'd0);
      chk("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
      chk("rst_serr", {31'd0, bus.sync_err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic frame 1,0,1,1 and one-cycle strobe.
      beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
      push_frame(4'b1011);
      beat(1'b0, 1'b1);
      chk("basic_fv", {31'd0, bus.frame_valid}, 32'd1);
      chk("basic_f", {28'd0, fpack()}, 32'hB);
      chk("basic_locked", {31'd0, bus.locked}, 32'd1);
      idle(1);
      chk("basic_fv_drop", {31'd0, bus.frame_valid}, 32'd0);

      // Back-to-back frames 1,0,0,0 and 0,1,1,0.
      beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
      push_frame(4'b1000);
      beat(1'b0, 1'b0);
      chk("b2b_fv1", {31'd0, bus.frame_valid}, 32'd1);
      beat(1'b1, 1'b0);
      chk("b2b_gap1", {31'd0, bus.frame_valid}, 32'd0);
      beat(1'b0, 1'b1);
      chk("b2b_gap2", {31'd0, bus.frame_valid}, 32'd0);
      beat(1'b0, 1'b1);
      chk("b2b_gap3", {31'd0, bus.frame_valid}, 32'd0);
      push_frame(4'b0110);
      beat(1'b0, 1'b0);
      chk("b2b_fv2", {31'd0, bus.frame_valid}, 32'd1);

      // Frame 1,1,0,1 with three idle cycles between beats.
      beat(1'b1, 1'b1); idle(3);
      chk("gap_locked", {31'd0, bus.locked}, 32'd1);
      beat(1'b0, 1'b1); idle(3);
      beat(1'b0, 1'b0); idle(3);
      chk("gap_f_hold", {28'd0, fpack()}, 32'h6);
      push_frame(4'b1101);
      beat(1'b0, 1'b1);
      chk("gap_f", {28'd0, fpack()}, 32'hD);
      idle(2);

      // Early sync at idx 2 restarts the frame from that beat.
      beat(1'b1, 1'b0); beat(1'b0, 1'b1);
      push_err();
      beat(1'b1, 1'b1);
      chk("early_serr", {31'd0, bus.sync_err}, 32'd1);
      chk("early_f_hold", {28'd0, fpack()}, 32'hD);
      chk("early_locked", {31'd0, bus.locked}, 32'd1);
      beat(1'b0, 1'b0); beat(1'b0, 1'b1);
      push_frame(4'b1010);
      beat(1'b0, 1'b0);
      chk("early_f", {28'd0, fpack()}, 32'hA);

      // Missing sync at idx 0 drops lock; non-sync beats ignored until next sync.
      push_err();
      beat(1'b0, 1'b1);
      chk("miss_serr", {31'd0, bus.sync_err}, 32'd1);
      chk("miss_locked", {31'd0, bus.locked}, 32'd0);
      beat(1'b0, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1); beat(1'b0, 1'b1);
      chk("hunt_locked", {31'd0, bus.locked}, 32'd0);
      chk("hunt_f_hold", {28'd0, fpack()}, 32'hA);
      beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
      push_frame(4'b0001);
      beat(1'b0, 1'b1);
      chk("relock_f", {28'd0, fpack()}, 32'h1);

      // Asynchronous reset mid-frame.
      beat(1'b1, 1'b1); beat(1'b0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_f", {28'd0, fpack()}, 32'd0);
      chk("arst_locked", {31'd0, bus.locked}, 32'd0);
      chk("arst_fv", {31'd0, bus.frame_valid}, 32'd0);
      last_f = 4'b0000;
      #1;
      rst = 1'b0;
      idle(1);
      beat(1'b0, 1'b1); beat(1'b0, 1'b1);
      chk("post_rst_locked", {31'd0, bus.locked}, 32'd0);
      beat(1'b1, 1'b0); beat(1'b0, 1'b1); beat(1'b0, 1'b1);
      push_frame(4'b0111);
      beat(1'b0, 1'b1);
      chk("post_rst_f", {28'd0, fpack()}, 32'h7);

`ifdef TDM_DEMUX_ERRCNT_EN
      rst = 1'b1;
      #1;
      chk("errcnt_rst", {24'd0, bus.err_cnt}, 32'd0);
      last_f = 4'b0000;
      rst = 1'b0;
      idle(1);
      beat(1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         push_err();
         beat(1'b1, 1'b0);
      end
      chk("errcnt_sat", {24'd0, bus.err_cnt}, 32'd255);
`endif

      idle(3);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Sequential 1-to-4 time-division demultiplexer; the receive-side counterpart of the 4-to-1 selector lab block.
- Accepts one serial beat per valid cycle, with a frame-sync marker on channel 0.
- Collects 4 beats per frame and presents them in parallel on f0..f3 with a one-cycle frame strobe.
- Sits between a serialised link or test source and the board LEDs/switch logic.

Parameters:
- DATA_W, 1, width of each channel sample (din and f0..f3).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  din/in_sync carry a beat this cycle
- in_sync  input  1  beat is channel 0 (frame start); ignored when in_valid=0
- din  input  DATA_W  serial sample
- f0  output  DATA_W  channel 0 of last complete frame
- f1  output  DATA_W  channel 1 of last complete frame
- f2  output  DATA_W  channel 2 of last complete frame
- f3  output  DATA_W  channel 3 of last complete frame
- frame_valid  output  1  one-cycle pulse: f0..f3 just updated
- locked  output  1  FSM in LOCK
- sync_err  output  1  one-cycle pulse: framing violation detected

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset (asserted at any time, including mid-frame): state=HUNT, idx=0, shadow[0..2]=0, f0..f3=0, frame_valid=0, locked=0, sync_err=0. Partial frame discarded.
- No beat (in_valid=0): no state, idx or shadow change. frame_valid and sync_err are forced to 0.
- HUNT state:
  - Beats with in_sync=0 are dropped.
  - Beat with in_sync=1: shadow[0]<=din, idx<=1, go LOCK.
- LOCK state, per beat:
  - idx in {1,2} and in_sync=0: shadow[idx]<=din, idx<=idx+1.
  - idx==3 and in_sync=0: f0<=shadow[0], f1<=shadow[1], f2<=shadow[2], f3<=din; frame_valid<=1 (next cycle); idx wraps to 0.
  - idx==0 and in_sync=1: normal frame start, shadow[0]<=din, idx<=1.
  - idx==0 and in_sync=0: missing sync. sync_err<=1, beat dropped, go HUNT.
  - idx in {1,2,3} and in_sync=1: early sync. sync_err<=1, partial frame discarded, beat taken as new channel 0 (shadow[0]<=din, idx<=1), stay LOCK, f0..f3 unchanged.
- Latency: f0..f3 and frame_valid change on the clock edge that samples the 4th beat. They are visible the cycle after that beat.
- Back-to-back frames (valid every cycle) give frame_valid every 4th cycle; no bubbles required.
- f0..f3 hold their value between frames and across sync errors; only a complete frame or rst changes them.
- locked = (state==LOCK), registered.
- Gaps (in_valid=0) inside a frame are legal and do not break lock.

Optional Feature:
- Macro: TDM_DEMUX_ERRCNT_EN.
- Defined: adds output err_cnt (8 bits) = number of sync_err pulses since reset. Saturates at 255. Reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package tdm_demux_pkg holds:
  - NCH=4, IDX_W=2
  - state enum {HUNT, LOCK}
  - ERRCNT_W=8
- One natural sub-module, tdm_demux_ctrl: FSM plus idx counter. It emits shadow write-enables, frame-complete and sync_err strobes.
- The top level holds the shadow and output registers.

Test Plan:
- Reset, then beats (sync,din) = (1,1),(0,0),(0,1),(0,1) on consecutive cycles -> cycle after 4th beat: f0..f3=1,0,1,1, frame_valid=1 for exactly 1 cycle, locked=1.
- Two back-to-back frames 1,0,0,0 then 0,1,1,0 -> frame_valid pulses 4 cycles apart; f=1,0,0,0 then 0,1,1,0.
- Frame with in_valid=0 gaps of 3 cycles between each beat -> same result as no gaps; locked stays 1.
- Locked, send sync beat at idx=2 -> sync_err pulse; f unchanged; next 3 non-sync beats complete a frame starting from that sync beat.
- Locked, beat with in_sync=0 at idx=0 -> sync_err pulse, locked=0; following non-sync beats ignored until next sync.
- Assert rst after 2 beats of a frame -> all outputs 0 immediately (asynchronous); with TDM_DEMUX_ERRCNT_EN, 300 sync errors give err_cnt=255.
